// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol, survivor-memory, traceback and decoded-bit signals of the Viterbi frame sequencer.
// The controller drives through 'master'; the surrounding datapath or bench uses 'slave'.
interface viterbi_frame_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              sym_valid;
    logic              sym_ready;
    logic [1:0]        sym_in;
    logic [1:0]        bmu_din;
    logic              acs_en;
    logic              acs_init;
    logic              sm_wr_en;
    logic [ADDR_W-1:0] sm_wr_addr;
    logic              sm_rd_en;
    logic [ADDR_W-1:0] sm_rd_addr;
    logic              tb_start;
    logic              tb_bit;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic              out_last;
    logic              busy;

    modport master (
        input  sym_valid, sym_in, tb_bit, out_ready,
        output sym_ready, bmu_din, acs_en, acs_init, sm_wr_en, sm_wr_addr,
               sm_rd_en, sm_rd_addr, tb_start, out_valid, out_bit, out_last, busy
    );

    modport slave (
        output sym_valid, sym_in, tb_bit, out_ready,
        input  sym_ready, bmu_din, acs_en, acs_init, sm_wr_en, sm_wr_addr,
               sm_rd_en, sm_rd_addr, tb_start, out_valid, out_bit, out_last, busy
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a rate-1/2 K=3 Viterbi decoder: loads symbols, strobes ACS/survivor
// writes, walks survivor memory backwards and re-emits the decoded bits in forward order.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int TAIL      = 2,
    parameter int ADDR_W    = 4,
    parameter int TB_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    viterbi_frame_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_STAGE = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_OUT   = ADDR_W'(FRAME_LEN - TAIL - 1);
    localparam logic [ADDR_W-1:0] KEEP       = ADDR_W'(FRAME_LEN - TAIL);
    localparam logic [2:0]        LAST_DRAIN = 3'(TB_LAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, TRACE, DRAIN, EMIT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] scnt, rcnt, kcnt;
    logic [2:0]        dcnt;
    logic              sym_ready_c, sym_hs, rd_en_c, out_hs;

    logic [1:0]        bmu_din_p0;
    logic              vld_p0, init_p0;
    logic [ADDR_W-1:0] wr_addr_p0;

    logic [TB_LAT-1:0] rd_vld_p;
    logic [ADDR_W-1:0] rd_addr_p [TB_LAT];
    logic [2**ADDR_W-1:0] rbuf;

    assign sym_ready_c = !rst && ((state == IDLE) || (state == LOAD));
    assign sym_hs      = bus.sym_valid && sym_ready_c;
    assign rd_en_c     = (state == TRACE);
    assign out_hs      = (state == EMIT) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (sym_hs) state_nxt = LOAD;
            LOAD:  if (sym_hs && (scnt == LAST_STAGE)) state_nxt = FLUSH;
            FLUSH: state_nxt = TRACE;
            TRACE: if (rcnt == '0) state_nxt = DRAIN;
            DRAIN: if (dcnt == LAST_DRAIN) state_nxt = EMIT;
            EMIT:  if (out_hs && (kcnt == LAST_OUT)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: symbol capture and per-symbol strobes; counters advance with their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt       <= '0;
            rcnt       <= '0;
            kcnt       <= '0;
            dcnt       <= '0;
            vld_p0     <= 1'b0;
            init_p0    <= 1'b0;
            bmu_din_p0 <= '0;
            wr_addr_p0 <= '0;
            rd_vld_p   <= '0;
        end else begin
            vld_p0  <= sym_hs;
            init_p0 <= sym_hs && (scnt == '0);
            if (sym_hs) begin
                bmu_din_p0 <= bus.sym_in;
                wr_addr_p0 <= scnt;
                scnt       <= (scnt == LAST_STAGE) ? '0 : scnt + 1'b1;
            end
            if (state == FLUSH)
                rcnt <= LAST_STAGE;
            else if (rd_en_c && (rcnt != '0))
                rcnt <= rcnt - 1'b1;
            if (state == DRAIN)
                dcnt <= (dcnt == LAST_DRAIN) ? '0 : dcnt + 1'b1;
            if (out_hs)
                kcnt <= (kcnt == LAST_OUT) ? '0 : kcnt + 1'b1;
            rd_vld_p[0] <= rd_en_c;
            for (int i = 1; i < TB_LAT; i++)
                rd_vld_p[i] <= rd_vld_p[i-1];
        end
    end

    // Stage p1..pTB_LAT: read address follows the traceback latency; tail stages are dropped.
    always_ff @(posedge clk) begin
        rd_addr_p[0] <= rcnt;
        for (int i = 1; i < TB_LAT; i++)
            rd_addr_p[i] <= rd_addr_p[i-1];
        if (!rst && rd_vld_p[TB_LAT-1] && (rd_addr_p[TB_LAT-1] < KEEP))
            rbuf[rd_addr_p[TB_LAT-1]] <= bus.tb_bit;
    end

    assign bus.sym_ready  = sym_ready_c;
    assign bus.bmu_din    = rst ? 2'b00 : bmu_din_p0;
    assign bus.acs_en     = vld_p0 && !rst;
    assign bus.sm_wr_en   = vld_p0 && !rst;
    assign bus.acs_init   = init_p0 && !rst;
    assign bus.sm_wr_addr = rst ? '0 : wr_addr_p0;
    assign bus.sm_rd_en   = rd_en_c && !rst;
    assign bus.sm_rd_addr = (rd_en_c && !rst) ? rcnt : '0;
    assign bus.tb_start   = rd_en_c && !rst && (rcnt == LAST_STAGE);
    assign bus.out_valid  = (state == EMIT) && !rst;
    assign bus.out_bit    = (state == EMIT) && !rst && rbuf[kcnt];
    assign bus.out_last   = (state == EMIT) && !rst && (kcnt == LAST_OUT);
    assign bus.busy       = (state != IDLE) && !rst;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: randomized frames, a traceback stub, and a
// frame-level reference model that predicts strobes, reads and forward-ordered bits.
module tb_viterbi_frame_ctrl;
    localparam int FL = 8, TL = 2, AW = 4, NOUT = FL - TL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_frame_ctrl_if #(.ADDR_W(AW)) vif ();

    viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL(TL), .ADDR_W(AW), .TB_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct packed {logic [3:0] addr; logic [1:0] sym; logic init;} wr_t;
    typedef struct packed {logic b; logic last;} out_t;

    wr_t  wr_q[$];
    int   rd_q[$];
    out_t out_q[$];

    int   checks = 0;
    int   failures = 0;
    int   inframe = 0;
    int   ready_mode = 0;
    int   out_idx = 0;
    int   stall_cnt = 0;
    logic rst_d = 1'b0;
    logic [7:0] cur_ref = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Traceback stub: bit for the address read one cycle earlier, noise otherwise.
    always @(posedge clk)
        vif.tb_bit <= vif.sm_rd_en ? cur_ref[vif.sm_rd_addr[2:0]] : 1'($urandom);

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: vif.out_ready = 1'b1;
            1: vif.out_ready = ($urandom_range(0, 3) != 0);
            default: vif.out_ready = !(out_idx == 2 && stall_cnt < 3);
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", 32'({vif.sym_ready, vif.bmu_din, vif.acs_en, vif.acs_init,
                vif.sm_wr_en, vif.sm_wr_addr, vif.sm_rd_en, vif.sm_rd_addr, vif.tb_start,
                vif.out_valid, vif.out_bit, vif.out_last, vif.busy}), 32'd0);
        end else if (rst_d) begin
            chk("post_reset_outputs", 32'({vif.bmu_din, vif.acs_en, vif.acs_init,
                vif.sm_wr_en, vif.sm_wr_addr, vif.sm_rd_en, vif.sm_rd_addr, vif.tb_start,
                vif.out_valid, vif.out_bit, vif.out_last, vif.busy}), 32'd0);
        end else begin
            chk("busy", 32'(vif.busy),
                32'((inframe > 0) || (rd_q.size() != 0) || (out_q.size() != 0)));
            if (rd_q.size() != 0 || out_q.size() != 0)
                chk("sym_ready_blocked", 32'(vif.sym_ready), 32'd0);
            if (vif.acs_en) begin
                if (wr_q.size() == 0) chk("unexpected_acs_en", 32'd1, 32'd0);
                else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("symbol_strobe", 32'({vif.sm_wr_en, vif.sm_wr_addr, vif.bmu_din, vif.acs_init}),
                        32'({1'b1, e.addr, e.sym, e.init}));
                end
            end else if (vif.acs_init || vif.sm_wr_en) begin
                chk("stray_wr_strobe", 32'({vif.acs_init, vif.sm_wr_en}), 32'd0);
            end
            if (vif.sm_rd_en) begin
                if (rd_q.size() == 0) chk("unexpected_sm_rd_en", 32'd1, 32'd0);
                else begin
                    int a;
                    a = rd_q.pop_front();
                    chk("trace_read", 32'({vif.sm_rd_addr, vif.tb_start}), 32'({4'(a), a == FL - 1}));
                end
            end else if (vif.tb_start) begin
                chk("stray_tb_start", 32'd1, 32'd0);
            end
            if (vif.out_valid) begin
                if (out_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
                else begin
                    out_t e;
                    e = out_q[0];
                    chk(vif.out_ready ? "out_bit" : "out_bit_stalled",
                        32'({vif.out_bit, vif.out_last}), 32'({e.b, e.last}));
                    if (vif.out_ready) begin
                        void'(out_q.pop_front());
                        out_idx = e.last ? 0 : out_idx + 1;
                        stall_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
        end
        rst_d = rst;
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        wr_q.delete();
        rd_q.delete();
        out_q.delete();
        inframe = 0;
        out_idx = 0;
        stall_cnt = 0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Sends nsym symbols of a frame; the model predicts everything the frame must produce.
    task automatic send_frame(input logic [1:0] syms [FL], input logic [7:0] refv,
                              input int gap_pct, input bit hold, input int nsym);
        for (int i = 0; i < nsym; i++) begin
            bit got;
            int w;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                vif.sym_valid = 1'b0;
                vif.sym_in = 2'($urandom);
                @(posedge clk);
                #1;
            end
            vif.sym_valid = 1'b1;
            vif.sym_in = syms[i];
            got = 1'b0;
            w = 0;
            while (!got && w < 300) begin
                @(negedge clk);
                got = vif.sym_ready;
                #1;
                if (got) begin
                    wr_q.push_back(wr_t'{addr: 4'(i), sym: syms[i], init: (i == 0)});
                    inframe = i + 1;
                    if (i == FL - 1) begin
                        inframe = 0;
                        cur_ref = refv;
                        for (int a = FL - 1; a >= 0; a--) rd_q.push_back(a);
                        for (int k = 0; k < NOUT; k++)
                            out_q.push_back(out_t'{b: refv[k], last: (k == NOUT - 1)});
                    end
                end
                @(posedge clk);
                #1;
                w++;
            end
            if (!got) begin
                chk("sym_accept_timeout", 32'd0, 32'd1);
                return;
            end
        end
        if (!hold) begin
            vif.sym_valid = 1'b0;
            vif.sym_in = 2'($urandom);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0 || out_q.size() != 0) && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (w >= 500) chk("drain_timeout", 32'(out_q.size() + rd_q.size() + wr_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [1:0] base_syms [FL] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    logic [1:0] rnd_syms [FL];
    localparam logic [7:0] BASE_REF = 8'b0000_1101;

    initial begin
        vif.sym_valid = 1'b0;
        vif.sym_in = 2'b00;
        do_reset(3);

        // Back-to-back frame with valid held, then trace and emit.
        send_frame(base_syms, BASE_REF, 0, 1'b0, FL);
        wait_idle();

        // Valid toggling during load, random sink back-pressure.
        ready_mode = 1;
        send_frame(base_syms, BASE_REF, 100, 1'b0, FL);
        wait_idle();

        // Sink stalls three cycles on bit index 2.
        ready_mode = 2;
        send_frame(base_syms, BASE_REF, 0, 1'b0, FL);
        wait_idle();

        // Abort at stage 4, then a clean frame.
        ready_mode = 0;
        send_frame(base_syms, BASE_REF, 0, 1'b1, 4);
        do_reset(1);
        vif.sym_valid = 1'b0;
        send_frame(base_syms, BASE_REF, 0, 1'b0, FL);
        wait_idle();

        // Valid held high through trace/emit across consecutive frames, then random frames.
        ready_mode = 1;
        for (int f = 0; f < 18; f++) begin
            logic [7:0] r;
            for (int i = 0; i < FL; i++) rnd_syms[i] = (i >= FL - TL) ? 2'b00 : 2'($urandom);
            r = 8'($urandom);
            ready_mode = (f % 3 == 2) ? 0 : 1;
            send_frame(rnd_syms, r, (f < 4) ? 0 : 30, (f < 4) ? 1'b1 : bit'($urandom_range(0, 1)), FL);
        end
        vif.sym_valid = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
